// File: rtl/dlfloat_mac_driver.sv
// rtl/dlfloat_mac_driver.sv - host-side operand/result driver for the dlfloat MAC link
// Optional DLMAC_SPECIAL_FLAG_EN adds per-word special-value flags (o_res_special).
module dlfloat_mac_driver #(
  parameter int          FIFO_DEPTH = 4,
  parameter int          RES_LAT    = 4,
  parameter logic [15:0] IDLE_WORD  = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_op_valid,
  output logic        o_op_ready,
  input  logic [15:0] i_op_a,
  input  logic [15:0] i_op_b,
  output logic [15:0] o_bus_out,
  input  logic [7:0]  i_byte_in,
  output logic        o_res_valid,
  input  logic        i_res_ready,
  output logic [15:0] o_res_data,
`ifdef DLMAC_SPECIAL_FLAG_EN
  output logic [1:0]  o_res_special,
`endif
  output logic        o_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic               r_tx_phase;
  logic [15:0]        r_bus_out;
  logic [15:0]        r_b_hold;
  logic               r_b_pend;
  logic [RES_LAT:0]   r_tag;
  logic [CW-1:0]      r_inflight;
  logic [7:0]         r_msb;
  logic               r_lsb_pend;
  logic [15:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;

  logic               w_credit_ok;
  logic               w_accept;
  logic               w_tag_exit;
  logic               w_push;
  logic               w_pop;
  logic [15:0]        w_word;

  // Credits count both queued words and pairs whose result is still on the wire.
  assign w_credit_ok = ({1'b0, r_count} + {1'b0, r_inflight}) < (CW + 1)'(FIFO_DEPTH);
  assign o_op_ready  = r_tx_phase && w_credit_ok;
  assign w_accept    = i_op_valid && o_op_ready;
  assign w_tag_exit  = r_tag[RES_LAT];
  assign w_push      = r_lsb_pend;
  assign w_pop       = o_res_valid && i_res_ready;
  assign w_word      = {r_msb, i_byte_in};

  assign o_bus_out   = r_bus_out;
  assign o_res_valid = (r_count != '0);
  assign o_res_data  = r_mem[r_rd_ptr];
  assign o_busy      = (r_inflight != '0) || (r_count != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_phase <= 1'b0;
      r_bus_out  <= IDLE_WORD;
      r_b_hold   <= '0;
      r_b_pend   <= 1'b0;
      r_tag      <= '0;
      r_inflight <= '0;
      r_msb      <= '0;
      r_lsb_pend <= 1'b0;
    end else begin
      r_tx_phase <= ~r_tx_phase;
      r_b_pend   <= w_accept;
      if (w_accept) begin
        r_bus_out <= i_op_a;
        r_b_hold  <= i_op_b;
      end else if (r_b_pend) begin
        r_bus_out <= r_b_hold;
      end else begin
        r_bus_out <= IDLE_WORD;
      end
      // Bit 0 is set on the B-slot edge; bit RES_LAT lines up with the MSB byte.
      r_tag      <= {r_tag[RES_LAT-1:0], r_b_pend};
      if (w_tag_exit) r_msb <= i_byte_in;
      r_lsb_pend <= w_tag_exit;
      r_inflight <= r_inflight + CW'(r_b_pend) - CW'(w_push);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_word;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

`ifdef DLMAC_SPECIAL_FLAG_EN
  logic [1:0] r_spec [FIFO_DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_spec[i] <= 2'b00;
    end else if (w_push) begin
      r_spec[r_wr_ptr] <= {w_word == 16'hFFFF, w_word == 16'h0000};
    end
  end

  assign o_res_special = r_spec[r_rd_ptr];
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst_n) assert (!(w_push && (r_count == CW'(FIFO_DEPTH))));
  end

endmodule

// File: tb/tb_dlfloat_mac_driver.sv
// tb/tb_dlfloat_mac_driver.sv - randomized scoreboard bench for dlfloat_mac_driver
// Build with DLMAC_SPECIAL_FLAG_EN to also cover o_res_special.
module tb_dlfloat_mac_driver;

  localparam int          DEPTH = 4;
  localparam int          LAT   = 4;
  localparam logic [15:0] IDLE  = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        res_ready = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic [7:0]  byte_in = '0;
  logic        op_ready;
  logic [15:0] bus_out;
  logic        res_valid;
  logic [15:0] res_data;
  logic        busy;
`ifdef DLMAC_SPECIAL_FLAG_EN
  logic [1:0]  res_special;
`endif

  dlfloat_mac_driver #(.FIFO_DEPTH(DEPTH), .RES_LAT(LAT), .IDLE_WORD(IDLE)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_op_valid(op_valid),
    .o_op_ready(op_ready),
    .i_op_a(op_a),
    .i_op_b(op_b),
    .o_bus_out(bus_out),
    .i_byte_in(byte_in),
    .o_res_valid(res_valid),
    .i_res_ready(res_ready),
    .o_res_data(res_data),
`ifdef DLMAC_SPECIAL_FLAG_EN
    .o_res_special(res_special),
`endif
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference state: cycle index, cycles since reset release, expected results in order.
  int          cyc = 0;
  int          rel = 0;
  logic [15:0] exp_q[$];
  logic        sched_v [64];
  logic [7:0]  sched_b [64];
  logic [15:0] exp_bus [64];
  int          acc_cnt = 0;
  int          acc_edge = 0;
  int          pop_cnt = 0;
  logic        use_ovr = 1'b0;
  logic [15:0] ovr = '0;
  logic [15:0] mon_r;
  logic [15:0] mon_e;

  // Stand-in MAC arithmetic; any deterministic function of the operands will do.
  function automatic logic [15:0] mac_result(input logic [15:0] a, input logic [15:0] b);
    return (a ^ {b[7:0], b[15:8]}) + 16'h1357;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rel <= rst_n ? rel + 1 : 0;
  end

  // MAC model: result bytes appear LAT cycles after the B slot, junk otherwise.
  always @(posedge clk) begin
    #1;
    if (sched_v[cyc % 64]) begin
      byte_in = sched_b[cyc % 64];
      sched_v[cyc % 64] = 1'b0;
    end else begin
      byte_in = 8'($urandom);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("bus_out", bus_out, exp_bus[cyc % 64]);
      exp_bus[cyc % 64] = IDLE;
      if (op_ready) check("ready_phase", rel % 2, 1);
      if (op_valid && op_ready) begin
        mon_r = use_ovr ? ovr : mac_result(op_a, op_b);
        exp_q.push_back(mon_r);
        exp_bus[(cyc + 1) % 64] = op_a;
        exp_bus[(cyc + 2) % 64] = op_b;
        sched_v[(cyc + 2 + LAT) % 64] = 1'b1;
        sched_b[(cyc + 2 + LAT) % 64] = mon_r[15:8];
        sched_v[(cyc + 3 + LAT) % 64] = 1'b1;
        sched_b[(cyc + 3 + LAT) % 64] = mon_r[7:0];
        acc_cnt++;
        acc_edge = cyc + 1;
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("pop_empty", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("res_data", res_data, mon_e);
`ifdef DLMAC_SPECIAL_FLAG_EN
          check("res_special", res_special, {30'd0, mon_e == 16'hFFFF, mon_e == 16'h0000});
`endif
        end
        pop_cnt++;
      end
    end
  end

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    op_valid = 1'b0;
    res_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      sched_v[i] = 1'b0;
      exp_bus[i] = IDLE;
    end
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the accept.
  task automatic send_pair(input logic [15:0] a, input logic [15:0] b,
                           input logic uo, input logic [15:0] o);
    int n0;
    n0 = acc_cnt;
    op_a = a; op_b = b; use_ovr = uo; ovr = o;
    op_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (acc_cnt != n0) break;
    end
    check("accept", acc_cnt - n0, 1);
    op_valid = 1'b0;
    use_ovr = 1'b0;
  endtask

  task automatic drain();
    res_ready = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !res_valid && !busy) break;
    end
    check("drained", {29'd0, exp_q.size() != 0, busy, res_valid}, 0);
    res_ready = 1'b0;
  endtask

  initial begin
    int pc, target, rp, exp_acc, vcnt;
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc, n0, target, rp, exp_acc, vcnt;
    for (int i = 0; i < 64; i++) begin
      sched_v[i] = 1'b0;
      exp_bus[i] = IDLE;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bus", bus_out, IDLE);
    check("rst_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", op_ready, 0);
    check("rst_data", res_data, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Single pair with a fixed result and exact latency.
    send_pair(16'h3E00, 16'h4000, 1'b1, 16'h4000);
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    check("latency", cyc - acc_edge, LAT + 3);
    check("single_data", res_data, 16'h4000);
    @(posedge clk); #1;
    drain();

    // Backpressure: only DEPTH pairs accepted, then one pop reopens a credit.
    n0 = acc_cnt;
    op_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      op_a = 16'($urandom); op_b = 16'($urandom);
    end
    @(negedge clk);
    check("fill_count", acc_cnt - n0, DEPTH);
    check("full_ready", op_ready, 0);
    check("full_busy", busy, 1);
    @(posedge clk); #1;
    res_ready = 1'b1;
    rp = rel;
    exp_acc = (rp % 2 == 0) ? cyc + 1 : cyc + 2;
    n0 = acc_cnt;
    @(posedge clk); #1;
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (acc_cnt != n0) break;
      @(posedge clk); #1;
    end
    check("reaccept_cyc", acc_edge - 1, exp_acc);
    op_valid = 1'b0;
    drain();

    // Push and pop in the same cycle with DEPTH-1 words queued.
    for (int k = 0; k < DEPTH; k++) send_pair(16'($urandom), 16'($urandom), 1'b0, '0);
    target = acc_edge + LAT + 2;
    while (cyc < target) begin
      @(posedge clk); #1;
    end
    check("pp_valid", res_valid, 1);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    repeat (8) @(posedge clk); #1;
    pc = pop_cnt;
    drain();
    check("pp_remaining", pop_cnt - pc, DEPTH - 1);

    // Sixteen sequential pairs through the pointer wrap.
    pc = pop_cnt;
    res_ready = 1'b1;
    for (int k = 0; k < 16; k++) send_pair(16'($urandom), 16'($urandom), 1'b0, '0);
    drain();
    check("wrap_pops", pop_cnt - pc, 16);

    // Random traffic with random consumer backpressure.
    for (int i = 0; i < 400; i++) begin
      op_valid  = ($urandom_range(0, 2) != 0);
      op_a      = 16'($urandom);
      op_b      = 16'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    op_valid = 1'b0;
    drain();

`ifdef DLMAC_SPECIAL_FLAG_EN
    send_pair(16'h1111, 16'h2222, 1'b1, 16'hFFFF);
    send_pair(16'h3333, 16'h4444, 1'b1, 16'h0000);
    send_pair(16'h5555, 16'h6666, 1'b1, 16'h4000);
    drain();
`endif

    // Reset between A and B slots drops the pair.
    send_pair(16'hABCD, 16'h1234, 1'b0, '0);
    rst_n = 1'b0;
    #1 check("midrst_bus", bus_out, IDLE);
    do_reset(2);
    res_ready = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid) vcnt++;
    end
    check("midrst_valid", vcnt, 0);
    check("midrst_busy", busy, 0);
    @(posedge clk); #1;
    res_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
